// File: rtl/fft_seq_param.sv
// In-place radix-4/radix-2 DIF FFT address sequencer over four RAM banks.
// Drives read/twiddle/write addresses and the start/busy/done handshake.
module fft_seq_param #(
  parameter int LOG2_N  = 11,
  parameter int BUT_LAT = 6
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iABORT,
  input  logic              iINV,
  output logic              oRD_EN,
  output logic [1:0]        oRD_BANK_0,
  output logic [1:0]        oRD_BANK_1,
  output logic [1:0]        oRD_BANK_2,
  output logic [1:0]        oRD_BANK_3,
  output logic [LOG2_N-3:0] oRD_ADDR_0,
  output logic [LOG2_N-3:0] oRD_ADDR_1,
  output logic [LOG2_N-3:0] oRD_ADDR_2,
  output logic [LOG2_N-3:0] oRD_ADDR_3,
  output logic [LOG2_N-3:0] oCOEF_ADDR,
  output logic              oWE,
  output logic [1:0]        oWR_BANK_0,
  output logic [1:0]        oWR_BANK_1,
  output logic [1:0]        oWR_BANK_2,
  output logic [1:0]        oWR_BANK_3,
  output logic [LOG2_N-3:0] oWR_ADDR_0,
  output logic [LOG2_N-3:0] oWR_ADDR_1,
  output logic [LOG2_N-3:0] oWR_ADDR_2,
  output logic [LOG2_N-3:0] oWR_ADDR_3,
  output logic              oBUT_TYPE,
  output logic              oINV,
  output logic [3:0]        oSTAGE,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int AW = LOG2_N - 2;
  localparam int NS = (LOG2_N + 1) / 2;
  localparam bit R2 = (LOG2_N % 2) == 1;
  localparam int NW = 2 * NS;

  typedef logic [LOG2_N-1:0] idx_t;
  typedef logic [AW-1:0]     adr_t;
  typedef logic [NW-1:0]     dig_t;

  localparam logic [3:0] SLAST = 4'(NS - 1);
  localparam logic [3:0] DLAST = 4'(BUT_LAT - 1);
  localparam adr_t       BLAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  // Lane k operand: base-4 digit k spliced into b at bit p.
  function automatic idx_t idx_of(
    input adr_t       bb,
    input logic [1:0] k,
    input logic [3:0] s,
    input logic       r2
  );
    idx_t be;
    idx_t kk;
    idx_t m;
    int   p;
    be = idx_t'(bb);
    kk = idx_t'(k);
    p  = r2 ? 0 : LOG2_N - 2 - 2 * int'(s);
    m  = (idx_t'(1) << p) - idx_t'(1);
    return ((be & ~m) << 2) | (kk << p) | (be & m);
  endfunction

  function automatic logic [1:0] bank_of(input idx_t n);
    dig_t       w;
    logic [1:0] acc;
    w   = dig_t'(n);
    acc = '0;
    for (int d = 0; d < NS; d++) begin
      acc = acc + w[2*d +: 2];
    end
    return acc;
  endfunction

  function automatic adr_t coef_of(
    input adr_t       bb,
    input logic [3:0] s,
    input logic       r2
  );
    adr_t m;
    int   p;
    p = AW - 2 * int'(s);
    m = (adr_t'(1) << p) - adr_t'(1);
    return r2 ? '0 : adr_t'((bb & m) << (2 * int'(s)));
  endfunction

  state_t     state;
  state_t     state_nxt;
  adr_t       b;
  adr_t       b_nxt;
  logic [3:0] stage;
  logic [3:0] stage_nxt;
  logic [3:0] dcnt;
  logic [3:0] dcnt_nxt;
  logic       inv_nxt;
  logic       done_nxt;

  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    stage_nxt = stage;
    dcnt_nxt  = dcnt;
    inv_nxt   = oINV;
    done_nxt  = 1'b0;
    if (iABORT) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            state_nxt = READ;
            b_nxt     = '0;
            stage_nxt = '0;
            inv_nxt   = iINV;
          end
        end
        READ: begin
          if (b == BLAST) begin
            state_nxt = DRAIN;
            dcnt_nxt  = '0;
          end else begin
            b_nxt = b + adr_t'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) begin
            if (stage == SLAST) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = READ;
              stage_nxt = stage + 4'd1;
              b_nxt     = '0;
            end
          end else begin
            dcnt_nxt = dcnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  idx_t       n_nxt    [4];
  logic [1:0] bank_nxt [4];
  adr_t       addr_nxt [4];
  adr_t       coef_nxt;
  logic       r2_nxt;

  // Addresses are precomputed for the next cycle so the ports are registers.
  always_comb begin
    r2_nxt   = R2 && (stage_nxt == SLAST);
    coef_nxt = coef_of(b_nxt, stage_nxt, r2_nxt);
    for (int k = 0; k < 4; k++) begin
      n_nxt[k]    = idx_of(b_nxt, 2'(k), stage_nxt, r2_nxt);
      bank_nxt[k] = bank_of(n_nxt[k]);
      addr_nxt[k] = n_nxt[k][LOG2_N-1:2];
    end
  end

  logic [1:0] rd_bank [4];
  adr_t       rd_addr [4];

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state      <= IDLE;
      b          <= '0;
      stage      <= '0;
      dcnt       <= '0;
      oRD_EN     <= 1'b0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oINV       <= 1'b0;
      oBUT_TYPE  <= 1'b0;
      oCOEF_ADDR <= '0;
      for (int k = 0; k < 4; k++) begin
        rd_bank[k] <= '0;
        rd_addr[k] <= '0;
      end
    end else begin
      state  <= state_nxt;
      b      <= b_nxt;
      stage  <= stage_nxt;
      dcnt   <= dcnt_nxt;
      oINV   <= inv_nxt;
      oDONE  <= done_nxt;
      oBUSY  <= (state_nxt != IDLE);
      oRD_EN <= (state_nxt == READ);
      if (state_nxt == READ) begin
        oBUT_TYPE  <= r2_nxt;
        oCOEF_ADDR <= coef_nxt;
        for (int k = 0; k < 4; k++) begin
          rd_bank[k] <= bank_nxt[k];
          rd_addr[k] <= addr_nxt[k];
        end
      end
    end
  end

  assign oSTAGE     = stage;
  assign oRD_BANK_0 = rd_bank[0];
  assign oRD_BANK_1 = rd_bank[1];
  assign oRD_BANK_2 = rd_bank[2];
  assign oRD_BANK_3 = rd_bank[3];
  assign oRD_ADDR_0 = rd_addr[0];
  assign oRD_ADDR_1 = rd_addr[1];
  assign oRD_ADDR_2 = rd_addr[2];
  assign oRD_ADDR_3 = rd_addr[3];

  logic       wp_en   [BUT_LAT];
  logic [1:0] wp_bank [BUT_LAT][4];
  adr_t       wp_addr [BUT_LAT][4];

  // Abort kills every in-flight write so nothing lands after the flush.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < BUT_LAT; i++) begin
        wp_en[i] <= 1'b0;
        for (int k = 0; k < 4; k++) begin
          wp_bank[i][k] <= '0;
          wp_addr[i][k] <= '0;
        end
      end
    end else begin
      for (int i = BUT_LAT - 1; i > 0; i--) begin
        wp_en[i] <= wp_en[i-1] & ~iABORT;
        for (int k = 0; k < 4; k++) begin
          wp_bank[i][k] <= wp_bank[i-1][k];
          wp_addr[i][k] <= wp_addr[i-1][k];
        end
      end
      wp_en[0] <= oRD_EN & ~iABORT;
      for (int k = 0; k < 4; k++) begin
        wp_bank[0][k] <= rd_bank[k];
        wp_addr[0][k] <= rd_addr[k];
      end
    end
  end

  assign oWE        = wp_en[BUT_LAT-1];
  assign oWR_BANK_0 = wp_bank[BUT_LAT-1][0];
  assign oWR_BANK_1 = wp_bank[BUT_LAT-1][1];
  assign oWR_BANK_2 = wp_bank[BUT_LAT-1][2];
  assign oWR_BANK_3 = wp_bank[BUT_LAT-1][3];
  assign oWR_ADDR_0 = wp_addr[BUT_LAT-1][0];
  assign oWR_ADDR_1 = wp_addr[BUT_LAT-1][1];
  assign oWR_ADDR_2 = wp_addr[BUT_LAT-1][2];
  assign oWR_ADDR_3 = wp_addr[BUT_LAT-1][3];

endmodule

// File: doc/fft_seq_param.md
Name: fft_seq_param

Overview:
- Parametrised in-place FFT sequencer for N = 2^LOG2_N points stored across 4 RAM banks, each of depth N/4.
- Uses radix-4 DIF stages, plus a final radix-2 stage when LOG2_N is odd.
- Generates per-lane bank/address for reads, twiddle address, delayed write addresses/enables, butterfly type, and a start/busy/done/abort handshake.
- Sits between the host load/unload logic and the 4-lane butterfly/multiplier datapath.

Parameters:
- LOG2_N, 11, log2 of FFT size; legal 4..14.
- BUT_LAT, 6, cycles from read address valid to butterfly result valid at the RAM write port; legal 1..15.
- Derived (localparam, not overridable): AW = LOG2_N-2; NS = ceil(LOG2_N/2) stages; R2 = LOG2_N odd.

Ports:
- iCLK  in  1  clock, rising edge
- iRESET  in  1  asynchronous active-low reset
- iSTART  in  1  start request; sampled only in IDLE
- iABORT  in  1  synchronous abort; returns to IDLE
- iINV  in  1  inverse-FFT flag; latched on accepted start
- oRD_EN  out  1  read addresses valid this cycle
- oRD_BANK_0..3  out  2 each  bank holding lane k operand
- oRD_ADDR_0..3  out  AW each  word address of lane k operand
- oCOEF_ADDR  out  AW  twiddle base index for this butterfly
- oWE  out  1  write enable, all 4 lanes
- oWR_BANK_0..3  out  2 each  write bank per lane
- oWR_ADDR_0..3  out  AW each  write address per lane
- oBUT_TYPE  out  1  0 = radix-4, 1 = two radix-2; aligned with oRD_EN
- oINV  out  1  latched iINV
- oSTAGE  out  4  current stage index
- oBUSY  out  1  high in READ/DRAIN
- oDONE  out  1  one-cycle completion pulse

Behaviour:
- Reset values: every output 0; state IDLE; write pipeline cleared.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on iSTART and not iABORT, go to READ with stage=0, b=0, and latch oINV=iINV.
  - READ: lasts N/4 cycles, b = 0..N/4-1, oRD_EN=1. After b=N/4-1, go to DRAIN.
  - DRAIN: lasts BUT_LAT cycles, oRD_EN=0. Then, if stage<NS-1, increment stage and go to READ with b=0; otherwise go to IDLE and pulse oDONE for the cycle after the last DRAIN cycle.
- iSTART in READ/DRAIN is ignored.
- iABORT in any state: next cycle is IDLE, oRD_EN=0, write pipeline flushed (oWE=0), no oDONE. Abort has priority over a simultaneous start.
- Operand indices, radix-4 stage s: L = N/4^(s+1), g = b/L, j = b mod L, n_k = 4gL + j + kL for lanes k=0..3. oBUT_TYPE=0.
- Operand indices, radix-2 stage (last stage when R2): n_k = 4b+k. Lanes 0,1 form one pair and lanes 2,3 the other. oBUT_TYPE=1.
- Bank/address mapping (conflict-free):
  - bank(n) = (sum of base-4 digits of n) mod 4, taken over LOG2_N bits; when R2 the top digit is 1 bit.
  - addr(n) = n >> 2.
  - The 4 lanes always hit 4 distinct banks.
- Twiddle address: oCOEF_ADDR = (j * 4^s) mod N/4 on radix-4 stages; 0 on the radix-2 stage. Downstream multiplies by lane k; conjugation is selected by oINV.
- Output timing: all read-side outputs are registered and valid in the cycles oRD_EN=1; they hold their last value otherwise.
- Write side: oWE and oWR_* equal oRD_EN and oRD_* delayed exactly BUT_LAT cycles (in-place writes). Writes of stage s complete within that stage's DRAIN, before stage s+1 reads.
- Busy timing: oBUSY is high for exactly NS*(N/4+BUT_LAT) cycles per run, then oDONE=1 with oBUSY=0.
- Output order: digit-reversed; reordering belongs to the unload block.
- oSTAGE holds the last stage value in IDLE; it is reset to 0 on start.

Test Plan:
- LOG2_N=4, BUT_LAT=2, start → stage0 b=0: banks 0,1,2,3, addrs 0,1,2,3; b=1: n=1,5,9,13, banks 1,2,3,0, addrs 0,1,2,3, coef 1. Stage1 b=0: banks 0,1,2,3, addrs 0,0,0,0, coef 0. oDONE after exactly 2*(4+2)=12 busy cycles.
- LOG2_N=5, BUT_LAT=3 → 3 stages; oBUT_TYPE=1 only in stage 2, where n_k=4b+k with coef 0. Busy = 3*(8+3) = 33 cycles.
- Default parameters, all stages → every oWR_* equals oRD_* from 6 cycles earlier; no cycle has duplicate lane banks; 3108 busy cycles; exactly 4*512*6 lane writes.
- iABORT mid-stage-2 → next cycle IDLE, oWE=0, no oDONE. A following iSTART restarts cleanly at stage 0, b=0.
- iSTART held high during a run, and pulsed on the same edge as oDONE → start ignored while busy; a new run begins only when iSTART is sampled in IDLE.
- iINV=1 at start, then iINV toggled during the run → oINV stays 1 for the whole run.
- iRESET asserted mid-READ → all outputs 0 asynchronously; state IDLE after release.
